// File: rtl/alu_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// Shared types and constants for the ALU operand-path arbiter.
//
// rysyPkg : core-wide datapath width (REG_LEN).
// alu2Pkg : second-operand select encoding, arbiter FSM states, port count
//           and the packed operand bundle captured at grant time.
//
// No ports; packages only.
// ---------------------------------------------------------------------------
package rysyPkg;
  localparam int REG_LEN = 32;
endpackage

package alu2Pkg;
  localparam int OP_W      = 4;
  localparam int ARB_PORTS = 2;

  // Second-operand mux leg: rs2 register data or the immediate.
  typedef enum logic {
    ALU2_RS  = 1'b0,
    ALU2_IMM = 1'b1
  } alu2_sel_e;

  // IDLE: nothing in flight; EXEC: operands on the ALU; HOLD: result parked.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_HOLD = 2'd2
  } arb_state;

  // Everything a requester hands to the ALU, latched as one unit.
  typedef struct packed {
    logic [rysyPkg::REG_LEN-1:0] rs1;
    logic [rysyPkg::REG_LEN-1:0] rs2;
    logic [rysyPkg::REG_LEN-1:0] imm;
    alu2_sel_e                   sel;
    logic [OP_W-1:0]             op;
  } alu_req_t;
endpackage

// File: rtl/alu_share_arb_pick.sv
// ---------------------------------------------------------------------------
// alu_rr_pick: 2-way request picker producing a one-hot (or zero) grant.
//
// Ports:
//   valid_i [1:0] : per-port request valid.
//   last_i        : port granted most recently (round-robin pointer).
//   grant_o [1:0] : one-hot grant, zero when nobody requests.
//
// Build option: ALU_ARB_FIXED_PRIO_EN
//   defined   -> port 0 always wins a tie, pointer input ignored.
//   undefined -> round-robin, the port not granted last wins a tie.
// ---------------------------------------------------------------------------
module alu_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Pointer is meaningless with fixed priority; keep it visibly unused.
  logic unusedLast;
  assign unusedLast = last_i;

  // Single requester wins outright; a tie always goes to port 0.
  always_comb begin
    grant_o = 2'b00;
    if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end
  end
`else
  // Single requester wins outright; on a tie the port that was not served
  // last gets the grant, so both ports alternate under sustained load.
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb: shares the core ALU operand path between the execute stage
// (port 0) and the auxiliary unit (port 1).
//
// A transaction is: accept (IDLE, req_ready pulse) -> EXEC (latched operands
// drive the ALU) -> HOLD (result parked on rsp_data until the owner takes it).
// Minimum three cycles per transaction; rsp_valid appears two cycles after
// the accept cycle.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset.
//   req_valid/req_ready    : per-port request handshake (ready one-hot/zero).
//   req_rs1/rs2/imm/sel/op : per-port operands, sampled in the accept cycle.
//   alu_in1/rs2/imm        : latched operands towards ALU and operand-2 mux.
//   alu2_sel, alu_op       : operand-2 mux select and ALU opcode.
//   alu_out                : combinational ALU result, captured during EXEC.
//   rsp_valid/rsp_ready    : per-port response handshake.
//   rsp_data               : held result, shared by both ports.
//
// Build option: ALU_ARB_FIXED_PRIO_EN (see alu_rr_pick) selects fixed
// priority instead of round-robin.
// ---------------------------------------------------------------------------
module alu_share_arb
  import alu2Pkg::*;
#(
  parameter int REG_LEN = rysyPkg::REG_LEN,
  parameter int OP_W    = alu2Pkg::OP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0][REG_LEN-1:0] req_rs1,
  input  logic [1:0][REG_LEN-1:0] req_rs2,
  input  logic [1:0][REG_LEN-1:0] req_imm,
  input  logic [1:0]              req_sel,
  input  logic [1:0][OP_W-1:0]    req_op,
  output logic [REG_LEN-1:0]      alu_in1,
  output logic [REG_LEN-1:0]      alu_rs2,
  output logic [REG_LEN-1:0]      alu_imm,
  output alu2_sel_e               alu2_sel,
  output logic [OP_W-1:0]         alu_op,
  input  logic [REG_LEN-1:0]      alu_out,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [REG_LEN-1:0]      rsp_data
);

  arb_state           stateQ;
  logic               ownerQ;
  logic               lastQ;
  alu_req_t           opQ;
  alu_req_t           opD;
  logic [REG_LEN-1:0] dataQ;
  logic [1:0]         rspValidQ;
  logic [1:0]         grant;
  logic               winner;
  logic               handshake;

  alu_rr_pick u_pick (
    .valid_i (req_valid),
    .last_i  (lastQ),
    .grant_o (grant)
  );

  assign winner = grant[1];

  // Operand bundle of whichever port the picker chose this cycle.
  always_comb begin
    opD     = '0;
    opD.rs1 = req_rs1[winner];
    opD.rs2 = req_rs2[winner];
    opD.imm = req_imm[winner];
    opD.sel = alu2_sel_e'(req_sel[winner]);
    opD.op  = req_op[winner];
  end

  // Only the owner's ready counts; the other port's ready is ignored.
  assign handshake = rspValidQ[ownerQ] & rsp_ready[ownerQ];

  // The accept has to be visible in the request cycle itself, so ready is
  // decoded from state; rst_n gates it so it is low while reset is held.
  assign req_ready = ((stateQ == ARB_IDLE) && rst_n) ? grant : 2'b00;

  // Transaction FSM. The operand register keeps its value after the
  // transaction, so the ALU inputs hold the last operands while idle.
  // Reset drops any in-flight transaction and returns the pointer to
  // port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= ARB_IDLE;
      ownerQ    <= 1'b0;
      lastQ     <= 1'b1;
      opQ       <= '0;
      dataQ     <= '0;
      rspValidQ <= 2'b00;
    end else begin
      unique case (stateQ)
        ARB_IDLE: begin
          if (|grant) begin
            opQ    <= opD;
            ownerQ <= winner;
            stateQ <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          dataQ     <= alu_out;
          rspValidQ <= ownerQ ? 2'b10 : 2'b01;
          stateQ    <= ARB_HOLD;
        end
        ARB_HOLD: begin
          if (handshake) begin
            rspValidQ <= 2'b00;
            lastQ     <= ownerQ;
            stateQ    <= ARB_IDLE;
          end
        end
        default: begin
          rspValidQ <= 2'b00;
          stateQ    <= ARB_IDLE;
        end
      endcase
    end
  end

  assign alu_in1   = opQ.rs1;
  assign alu_rs2   = opQ.rs2;
  assign alu_imm   = opQ.imm;
  assign alu2_sel  = opQ.sel;
  assign alu_op    = opQ.op;
  assign rsp_valid = rspValidQ;
  assign rsp_data  = dataQ;

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// Testbench for alu_share_arb: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a transaction
// level model of the arbiter. Honours ALU_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;
  import alu2Pkg::*;

  logic             clk;
  logic             rstN;
  logic [1:0]       reqValid;
  logic [1:0]       reqReady;
  logic [1:0][31:0] reqRs1;
  logic [1:0][31:0] reqRs2;
  logic [1:0][31:0] reqImm;
  logic [1:0]       reqSel;
  logic [1:0][3:0]  reqOp;
  logic [31:0]      aluIn1;
  logic [31:0]      aluRs2;
  logic [31:0]      aluImm;
  alu2_sel_e        aluSel;
  logic [3:0]       aluOp;
  logic [31:0]      aluOut;
  logic [1:0]       rspValid;
  logic [1:0]       rspReady;
  logic [31:0]      rspData;

  int checkCount = 0;
  int errorCount = 0;
  bit compareEn  = 0;
  int grantLog[$];

  alu_share_arb dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_rs1   (reqRs1),
    .req_rs2   (reqRs2),
    .req_imm   (reqImm),
    .req_sel   (reqSel),
    .req_op    (reqOp),
    .alu_in1   (aluIn1),
    .alu_rs2   (aluRs2),
    .alu_imm   (aluImm),
    .alu2_sel  (aluSel),
    .alu_op    (aluOp),
    .alu_out   (aluOut),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_data  (rspData)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: small opcode set, enough to make results distinguishable.
  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a & b;
      default: return a | b;
    endcase
  endfunction

  always_comb aluOut = aluFn(aluIn1, (aluSel == ALU2_IMM) ? aluImm : aluRs2, aluOp);

  // Arbitration rule: lone requester wins, a tie goes to the port not
  // served last (or always port 0 with fixed priority).
  function automatic logic [1:0] pickModel(input logic [1:0] v, input logic last);
    if (v != 2'b11) return v;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    return last ? 2'b01 : 2'b10;
`endif
  endfunction

  // Transaction model: phase counts cycles into the current transaction
  // (0 = nothing in flight, 1 = one cycle after accept, 2 = result parked).
  int          mPhase;
  logic        mOwner;
  logic        mLast;
  logic [31:0] mIn1, mRs2, mImm, mResult, mData;
  logic        mSel;
  logic [3:0]  mOp;

  always @(posedge clk or negedge rstN) begin
    logic [1:0] g;
    logic       w;
    if (!rstN) begin
      mPhase = 0; mOwner = 1'b0; mLast = 1'b1;
      mIn1 = '0; mRs2 = '0; mImm = '0; mSel = 1'b0; mOp = '0;
      mResult = '0; mData = '0;
    end else begin
      if (mPhase == 0) begin
        if (reqValid != 2'b00) begin
          g = pickModel(reqValid, mLast);
          w = g[1];
          mOwner = w;
          mIn1 = reqRs1[w]; mRs2 = reqRs2[w]; mImm = reqImm[w];
          mSel = reqSel[w]; mOp = reqOp[w];
          mResult = aluFn(mIn1, mSel ? mImm : mRs2, mOp);
          mPhase = 1;
        end
      end else if (mPhase == 1) begin
        mData = mResult;
        mPhase = 2;
      end else if (rspReady[mOwner]) begin
        mLast = mOwner;
        mPhase = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [1:0] expReady;
    logic [1:0] expValid;
    if (compareEn) begin
      expReady = (mPhase == 0 && rstN) ? pickModel(reqValid, mLast) : 2'b00;
      expValid = (mPhase == 2) ? (mOwner ? 2'b10 : 2'b01) : 2'b00;
      checkOutput("req_ready", {30'd0, reqReady}, {30'd0, expReady});
      checkOutput("rsp_valid", {30'd0, rspValid}, {30'd0, expValid});
      checkOutput("rsp_data", rspData, mData);
      checkOutput("alu_in1", aluIn1, mIn1);
      checkOutput("alu_rs2", aluRs2, mRs2);
      checkOutput("alu_imm", aluImm, mImm);
      checkOutput("alu2_sel", {31'd0, aluSel}, {31'd0, mSel});
      checkOutput("alu_op", {28'd0, aluOp}, {28'd0, mOp});
      if (reqReady != 2'b00) grantLog.push_back(reqReady[1] ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input int port, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic sel, input logic [3:0] op);
    reqValid     = valid;
    reqRs1[port] = rs1;
    reqRs2[port] = rs2;
    reqImm[port] = imm;
    reqSel[port] = sel;
    reqOp[port]  = op;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    reqValid = 2'b00;
    step();
    step();
    rstN = 1'b1;
  endtask

  initial begin
    int g0, g1, g2;
    rstN = 1'b0; reqValid = '0; reqRs1 = '0; reqRs2 = '0; reqImm = '0;
    reqSel = '0; reqOp = '0; rspReady = '0;
    step();
    step();
    checkOutput("reset rsp_valid", {30'd0, rspValid}, 32'd0);
    checkOutput("reset rsp_data", rspData, 32'd0);
    checkOutput("reset alu2_sel", {31'd0, aluSel}, 32'd0);
    rstN = 1'b1;
    compareEn = 1'b1;

    // Single request from port 0: 5 + imm 7.
    rspReady = 2'b11;
    applyStimulus(2'b01, 0, 32'd5, 32'd0, 32'd7, 1'b1, 4'd0);
    @(negedge clk);
    checkOutput("t1 req_ready c0", {30'd0, reqReady}, 32'd1);
    step();
    reqValid = 2'b00;
    @(negedge clk);
    checkOutput("t1 alu2_sel c1", {31'd0, aluSel}, 32'd1);
    @(negedge clk);
    checkOutput("t1 rsp_valid c2", {30'd0, rspValid}, 32'd1);
    checkOutput("t1 rsp_data c2", rspData, 32'd12);
    step();

    // Both ports requesting for three back-to-back rounds.
    doReset();
    grantLog.delete();
    applyStimulus(2'b11, 0, 32'd10, 32'd3, 32'd0, 1'b0, 4'd1);
    applyStimulus(2'b11, 1, 32'd20, 32'd0, 32'd4, 1'b1, 4'd2);
    repeat (9) step();
    reqValid = 2'b00;
    checkOutput("t2 grant count", grantLog.size(), 32'd3);
    g0 = grantLog.size() > 0 ? grantLog[0] : -1;
    g1 = grantLog.size() > 1 ? grantLog[1] : -1;
    g2 = grantLog.size() > 2 ? grantLog[2] : -1;
    checkOutput("t2 grant[0]", g0, 32'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    checkOutput("t2 grant[1]", g1, 32'd0);
`else
    checkOutput("t2 grant[1]", g1, 32'd1);
`endif
    checkOutput("t2 grant[2]", g2, 32'd0);

    // Port 1 overflow add, backpressured; non-owner ready and a port 1
    // pulse arrive while the result is parked.
    doReset();
    rspReady = 2'b01;
    applyStimulus(2'b10, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd0);
    step();
    reqValid = 2'b00;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) applyStimulus(2'b10, 1, 32'd9, 32'd9, 32'd9, 1'b0, 4'd0);
      else        applyStimulus(2'b01, 0, 32'd8, 32'd8, 32'd8, 1'b1, 4'd2);
      @(negedge clk);
      checkOutput("t3 rsp_valid hold", {30'd0, rspValid}, 32'd2);
      checkOutput("t3 rsp_data hold", rspData, 32'd0);
      checkOutput("t3 req_ready hold", {30'd0, reqReady}, 32'd0);
      step();
    end
    reqValid = 2'b00;
    rspReady = 2'b10;
    step();
    @(negedge clk);
    checkOutput("t3 rsp_valid after", {30'd0, rspValid}, 32'd0);
    step();

    // Complete a port 0 transaction, start another, reset during EXEC.
    doReset();
    rspReady = 2'b11;
    applyStimulus(2'b01, 0, 32'd6, 32'd0, 32'd6, 1'b1, 4'd0);
    step();
    reqValid = 2'b00;
    step();
    step();
    applyStimulus(2'b01, 0, 32'h1234_5678, 32'd1, 32'h0F0F_0F0F, 1'b1, 4'd3);
    step();
    reqValid = 2'b00;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t4 rst alu_in1", aluIn1, 32'd0);
    checkOutput("t4 rst alu_imm", aluImm, 32'd0);
    checkOutput("t4 rst alu2_sel", {31'd0, aluSel}, 32'd0);
    checkOutput("t4 rst alu_op", {28'd0, aluOp}, 32'd0);
    checkOutput("t4 rst rsp_data", rspData, 32'd0);
    step();
    rstN = 1'b1;
    applyStimulus(2'b11, 0, 32'd1, 32'd2, 32'd3, 1'b0, 4'd0);
    applyStimulus(2'b11, 1, 32'd4, 32'd5, 32'd6, 1'b1, 4'd1);
    @(negedge clk);
    checkOutput("t4 first tie", {30'd0, reqReady}, 32'd1);
    step();
    reqValid = 2'b00;
    repeat (3) step();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      reqValid = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        reqRs1[p] = $urandom();
        reqRs2[p] = $urandom();
        reqImm[p] = $urandom();
        reqSel[p] = 1'($urandom_range(0, 1));
        reqOp[p]  = 4'($urandom_range(0, 5));
      end
      rspReady = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rstN = 1'b0;
        #1;
        rstN = 1'b1;
      end
      step();
    end
    reqValid = 2'b00;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
